// File: rtl/mul4_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   DEF_WIDTH : default operand width
//   state_t   : control FSM states (IDLE, CALC, DONE)
//   clog2     : ceiling log2, used to size the step counter
package mul_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul4_shift_add_if.sv
// Operand/result bundle between the issue logic and the multiplier.
//   start : request, sampled when the multiplier is not busy
//   a, b  : multiplicand / multiplier (WIDTH bits)
//   busy  : iteration in progress
//   done  : one-cycle pulse when p is updated
//   p     : 2*WIDTH-bit product, held until the next completion
// master = operand issuer, slave = multiplier.
interface mul4_shift_add_if
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );

endinterface

// File: rtl/mul4_shift_add_add_stage.sv
// Combinational WIDTH-bit ripple-carry adder built from full-adder cells.
//   a, b : addends
//   ci   : carry in
//   s    : sum
//   co   : carry out
module mul_add_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[WIDTH];

endmodule

// File: rtl/mul4_shift_add.sv
// Sequential shift-and-add unsigned multiplier.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (aborts any operation)
//   bus   : slave side of mul4_shift_add_if (start, a, b, busy, done, p)
// One add/shift step per cycle for WIDTH cycles; done pulses for one
// cycle with p updated on the same edge. start is accepted in IDLE and
// DONE, ignored while in CALC.
module mul4_shift_add
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    mul4_shift_add_if.slave  bus
);

    localparam int unsigned CW = clog2(WIDTH + 1);

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mcand, mcand_nxt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [CW-1:0]        count, count_nxt;
    logic                 busy_q, busy_nxt;
    logic                 done_q, done_nxt;
    logic [2*WIDTH-1:0]   p_q, p_nxt;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 carry;
    logic [2*WIDTH-1:0]   acc_step;

    // Upper half of acc plus the multiplicand when the current multiplier
    // bit (acc[0]) is set.
    assign addend = acc[0] ? mcand : '0;

    mul_add_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .a  (acc[2*WIDTH-1:WIDTH]),
        .b  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (carry)
    );

    // Carry re-enters at the MSB so the full 2*WIDTH product is kept.
    assign acc_step = {carry, sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            p_q    <= '0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            acc    <= acc_nxt;
            count  <= count_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            p_q    <= p_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mcand_nxt = mcand;
        acc_nxt   = acc;
        count_nxt = count;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        p_nxt     = p_q;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (bus.start) begin
                    mcand_nxt = bus.a;
                    acc_nxt   = {{WIDTH{1'b0}}, bus.b};
                    count_nxt = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_nxt   = acc_step;
                count_nxt = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    p_nxt     = acc_step;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;

endmodule

// File: tb/tb_mul4_shift_add.sv
// Directed testbench for mul4_shift_add (WIDTH=4).
module tb_mul4_shift_add;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [7:0] last_p;

    mul4_shift_add_if #(.WIDTH(4)) bus ();

    mul4_shift_add #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check the full timeline. Caller is 1 unit
    // after a rising edge; the next edge is edge k.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] exp, input string tag);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb;
        tick(); // edge k
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb;
        check({tag, "_busy_k"}, 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check({tag, "_busy_mid"}, 32'(bus.busy), 32'd1);
            check({tag, "_done_mid"}, 32'(bus.done), 32'd0);
            check({tag, "_p_hold"}, 32'(bus.p), 32'(last_p));
        end
        tick(); // edge k+4
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, "_p"}, 32'(bus.p), 32'(exp));
        last_p = exp;
        tick(); // edge k+5
        check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
        check({tag, "_p_keep"}, 32'(bus.p), 32'(exp));
    endtask

    initial begin
        int pulses;
        checks    = 0;
        failures  = 0;
        last_p    = 8'h00;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_p", 32'(bus.p), 32'h00);
        rst_n = 1'b1;
        pulses = 0;
        repeat (3) begin
            tick();
            if (bus.done) pulses++;
        end
        check("rst_no_done", 32'(pulses), 32'd0);

        run_op(4'd5, 4'd3, 8'd15, "basic");
        run_op(4'hF, 4'hF, 8'hE1, "max");
        run_op(4'h0, 4'hF, 8'h00, "zero_a");
        run_op(4'hC, 4'h0, 8'h00, "zero_b");
        run_op(4'hA, 4'hD, 8'h82, "a10b13");

        // Start while busy is ignored
        bus.start = 1'b1; bus.a = 4'd2; bus.b = 4'd7;
        tick(); // edge k accepts
        bus.a = 4'd9; bus.b = 4'd9; // start still high for edge k+1
        tick();
        bus.start = 1'b0;
        pulses = 0;
        repeat (2) begin
            tick();
            if (bus.done) pulses++;
        end
        tick(); // edge k+4
        check("ign_done", 32'(bus.done), 32'd1);
        check("ign_p", 32'(bus.p), 32'd14);
        repeat (8) begin
            tick();
            if (bus.done) pulses++;
        end
        check("ign_single_pulse", 32'(pulses), 32'd0);
        check("ign_p_keep", 32'(bus.p), 32'd14);

        // Back-to-back with start held high
        bus.start = 1'b1; bus.a = 4'd3; bus.b = 4'd4;
        tick(); // edge k
        repeat (3) tick();
        tick(); // edge k+4 (DONE cycle)
        check("b2b_done1", 32'(bus.done), 32'd1);
        check("b2b_p1", 32'(bus.p), 32'd12);
        bus.a = 4'd6; bus.b = 4'd6;
        tick(); // edge k+5 accepts second
        check("b2b_done1_clr", 32'(bus.done), 32'd0);
        check("b2b_busy2", 32'(bus.busy), 32'd1);
        repeat (3) begin
            tick();
            check("b2b_mid_done", 32'(bus.done), 32'd0);
        end
        tick(); // edge k+9
        check("b2b_done2", 32'(bus.done), 32'd1);
        check("b2b_p2", 32'(bus.p), 32'd36);
        bus.start = 1'b0;
        tick();
        check("b2b_idle_busy", 32'(bus.busy), 32'd0);
        check("b2b_idle_done", 32'(bus.done), 32'd0);

        // Asynchronous reset mid-operation
        bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd7;
        tick(); // edge k
        bus.start = 1'b0;
        tick(); tick(); // after edge k+2
        check("ar_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_done", 32'(bus.done), 32'd0);
        check("ar_p", 32'(bus.p), 32'h00);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            tick();
            if (bus.done || bus.busy) pulses++;
        end
        check("ar_no_done", 32'(pulses), 32'd0);
        last_p = 8'h00;
        run_op(4'd7, 4'd7, 8'd49, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
